// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_fetch_unit                                                   |
// | Purpose  : Owns the PC. Issues instruction-memory reads with a REN/ihit    |
// |            handshake, registers the returned word and offers it to decode  |
// |            with a valid/ready handshake. Control-flow resolutions arrive   |
// |            as a PCSrc-encoded strobe and redirect the fetch stream.        |
// | Ports    : CLK, nRST            clock / async active-low reset            |
// |            imemREN, imemaddr    read request and word address to imem     |
// |            ihit, imemload       imem response strobe and data             |
// |            instr_valid, instr,  fetched word and its fall-through npc     |
// |            instr_npc, dec_ready decode handshake                          |
// |            redir_valid, PCSrc,  redirect strobe, source select and        |
// |            redir_npc, jaddr,    target operands                           |
// |            jr_addr, br_imm,                                               |
// |            br_taken                                                       |
// |            halt                 stop fetching until reset                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pc_fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_npc,
  input  logic        dec_ready,
  input  logic        redir_valid,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] redir_npc,
  input  logic [25:0] jaddr,
  input  logic [31:0] jr_addr,
  input  logic [15:0] br_imm,
  input  logic        br_taken,
  input  logic        halt
);

  localparam logic [1:0] C_SRC_ADD4   = 2'd0;
  localparam logic [1:0] C_SRC_JUMP   = 2'd1;
  localparam logic [1:0] C_SRC_JR     = 2'd2;
  localparam logic [1:0] C_SRC_BRANCH = 2'd3;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        pend_q, pend_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  // Holds REN low for the first cycle after reset release so a response
  // still in flight from before reset is never accepted.
  logic        started_q, started_d;
  // Remembers a halt pulse seen while a request is still outstanding.
  logic        halt_seen_q, halt_seen_d;

  logic        w_ren;
  logic        w_hit;
  logic        w_redir;
  logic        w_halt;
  logic [31:0] w_target;

  assign w_ren   = (state_q == ST_FETCH) && started_q;
  assign w_hit   = ihit && w_ren;
  assign w_redir = redir_valid && (PCSrc != C_SRC_ADD4);
  assign w_halt  = halt || halt_seen_q;

  always_comb begin
    w_target = redir_npc;
    case (PCSrc)
      C_SRC_JUMP:   w_target = {redir_npc[31:28], jaddr, 2'b00};
      C_SRC_JR:     w_target = jr_addr & ~32'h3;
      C_SRC_BRANCH: w_target = br_taken ? (redir_npc + {{14{br_imm[15]}}, br_imm, 2'b00})
                                        : redir_npc;
      default:      w_target = redir_npc;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    pend_d      = pend_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    npc_d       = npc_q;
    started_d   = 1'b1;
    halt_seen_d = w_halt;
    case (state_q)
      ST_FETCH: begin
        if (w_hit) begin
          pend_d = 1'b0;
          if (w_halt) begin
            state_d = ST_HALT;
          end else if (w_redir || pend_q) begin
            // Word belongs to the wrong path; a fresh redirect beats a pending one.
            pc_d = w_redir ? w_target : tgt_q;
          end else begin
            instr_d = imemload;
            npc_d   = pc_q + 32'd4;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = ST_HOLD;
          end
        end else if (w_redir && !w_halt) begin
          if (w_ren) begin
            // Address must not move mid-request; park the target until ihit.
            tgt_d  = w_target;
            pend_d = 1'b1;
          end else begin
            pc_d = w_target;
          end
        end
      end
      ST_HOLD: begin
        if (w_halt) begin
          valid_d = 1'b0;
          state_d = ST_HALT;
        end else if (w_redir) begin
          valid_d = 1'b0;
          pc_d    = w_target;
          state_d = ST_FETCH;
        end else if (dec_ready) begin
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      default: begin
        valid_d = 1'b0;
        pend_d  = 1'b0;
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_FETCH;
      pc_q        <= PC_INIT;
      tgt_q       <= 32'h0;
      pend_q      <= 1'b0;
      valid_q     <= 1'b0;
      instr_q     <= 32'h0;
      npc_q       <= 32'h0;
      started_q   <= 1'b0;
      halt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      pend_q      <= pend_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      npc_q       <= npc_d;
      started_q   <= started_d;
      halt_seen_q <= halt_seen_d;
    end
  end

  assign imemREN     = w_ren;
  assign imemaddr    = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_npc   = npc_q;

endmodule
`default_nettype wire
